// File: rtl/decode_pkg.sv
// MIPS opcode/funct encodings, instruction class and the per-instruction decoded bundle.
// The XLEN-wide immediate lives beside decoded_t in each consumer's own entry typedef.
package decode_pkg;

   localparam logic [5:0] OP_SPECIAL  = 6'h00;
   localparam logic [5:0] OP_J        = 6'h02;
   localparam logic [5:0] OP_JAL      = 6'h03;
   localparam logic [5:0] OP_BEQ      = 6'h04;
   localparam logic [5:0] OP_BNE      = 6'h05;
   localparam logic [5:0] OP_BGTZ     = 6'h07;
   localparam logic [5:0] OP_ADDI     = 6'h08;
   localparam logic [5:0] OP_ADDIU    = 6'h09;
   localparam logic [5:0] OP_SLTI     = 6'h0A;
   localparam logic [5:0] OP_SLTIU    = 6'h0B;
   localparam logic [5:0] OP_ANDI     = 6'h0C;
   localparam logic [5:0] OP_ORI      = 6'h0D;
   localparam logic [5:0] OP_XORI     = 6'h0E;
   localparam logic [5:0] OP_LUI      = 6'h0F;
   localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
   localparam logic [5:0] OP_LB       = 6'h20;
   localparam logic [5:0] OP_LW       = 6'h23;
   localparam logic [5:0] OP_LBU      = 6'h24;
   localparam logic [5:0] OP_SB       = 6'h28;
   localparam logic [5:0] OP_SW       = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_MUL   = 6'h02;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   typedef enum logic [1:0] {
      CLS_R   = 2'b00,
      CLS_I   = 2'b01,
      CLS_J   = 2'b10,
      CLS_ILL = 2'b11
   } class_e;

   typedef struct packed {
      logic [31:0] insn;
      logic [5:0]  opcode;
      logic [5:0]  funct;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [25:0] jtarget;
      class_e      cls;
      logic [4:0]  dest;
      logic        reg_write;
      logic        illegal;
      logic        is_nop;
   } decoded_t;

   function automatic logic r_funct_legal(input logic [5:0] fn);
      case (fn)
         FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR, FN_JALR,
         FN_MFHI, FN_MFLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
         FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
         FN_SLT, FN_SLTU: return 1'b1;
         default:         return 1'b0;
      endcase
   endfunction

   // HI/LO producers and JR leave the register file untouched
   function automatic logic r_funct_writes_rd(input logic [5:0] fn);
      return !(fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_JR});
   endfunction

endpackage

// File: rtl/mips_field_decoder.sv
// Combinational MIPS field decoder: classifies one instruction word, extends its
// immediate to XLEN and resolves the destination register.
module mips_field_decoder
   import decode_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int BR_SHIFT = 1
) (
   input  logic [31:0]     insn,
   output decoded_t        fields,
   output logic [XLEN-1:0] imm
);

   logic [15:0]     imm16;
   logic [XLEN-1:0] imm_sext, imm_zext, imm_lui, imm_br;
   class_e          cls;
   logic [4:0]      dest;
   logic            illegal;

   assign imm16    = insn[15:0];
   assign imm_sext = XLEN'($signed(imm16));
   assign imm_zext = XLEN'(imm16);
   assign imm_lui  = XLEN'($signed({imm16, 16'h0000}));
   assign imm_br   = (BR_SHIFT != 0) ? XLEN'($signed({imm16, 2'b00})) : imm_sext;

   always_comb begin
      cls     = CLS_ILL;
      dest    = 5'd0;
      illegal = 1'b1;
      imm     = '0;
      case (insn[31:26])
         OP_SPECIAL: begin
            if (r_funct_legal(insn[5:0])) begin
               cls     = CLS_R;
               illegal = 1'b0;
               dest    = r_funct_writes_rd(insn[5:0]) ? insn[15:11] : 5'd0;
            end
         end
         OP_SPECIAL2: begin
            if (insn[5:0] == FN_MUL) begin
               cls     = CLS_R;
               illegal = 1'b0;
               dest    = insn[15:11];
            end
         end
         OP_J, OP_JAL: begin
            cls     = CLS_J;
            illegal = 1'b0;
            dest    = (insn[31:26] == OP_JAL) ? 5'd31 : 5'd0;
         end
         OP_BEQ, OP_BNE, OP_BGTZ: begin
            cls     = CLS_I;
            illegal = 1'b0;
            imm     = imm_br;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LB, OP_LW, OP_LBU: begin
            cls     = CLS_I;
            illegal = 1'b0;
            imm     = imm_sext;
            dest    = insn[20:16];
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            cls     = CLS_I;
            illegal = 1'b0;
            imm     = imm_zext;
            dest    = insn[20:16];
         end
         OP_LUI: begin
            cls     = CLS_I;
            illegal = 1'b0;
            imm     = imm_lui;
            dest    = insn[20:16];
         end
         OP_SB, OP_SW: begin
            cls     = CLS_I;
            illegal = 1'b0;
            imm     = imm_sext;
         end
         default: ;
      endcase
   end

   always_comb begin
      fields           = '0;
      fields.insn      = insn;
      fields.opcode    = insn[31:26];
      fields.rs        = insn[25:21];
      fields.rt        = insn[20:16];
      fields.rd        = insn[15:11];
      fields.shamt     = insn[10:6];
      fields.funct     = insn[5:0];
      fields.jtarget   = insn[25:0];
      fields.cls       = cls;
      fields.dest      = dest;
      fields.illegal   = illegal;
      fields.reg_write = !illegal && (dest != 5'd0);
      fields.is_nop    = (insn == 32'h0);
   end

endmodule

// File: rtl/decode_pipe.sv
// Flow-controlled MIPS decode stage: decodes on the input side and holds results in a
// main register backed by a skid register so in_ready can be registered.
module decode_pipe
   import decode_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int CNT_WIDTH = 16,
   parameter int BR_SHIFT  = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_pc,
   input  logic [31:0]          in_insn,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_pc,
   output logic [31:0]          out_insn,
   output logic [5:0]           out_opcode,
   output logic [5:0]           out_funct,
   output logic [4:0]           out_rs,
   output logic [4:0]           out_rt,
   output logic [4:0]           out_rd,
   output logic [4:0]           out_shamt,
   output logic [XLEN-1:0]      out_imm,
   output logic [25:0]          out_jtarget,
   output logic [1:0]           out_class,
   output logic [4:0]           out_dest,
   output logic                 out_reg_write,
   output logic                 out_illegal,
   output logic                 out_is_nop,
   output logic [CNT_WIDTH-1:0] decoded_count
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      decoded_t        f;
   } entry_t;

   entry_t          in_entry, main_q, main_d, skid_q, skid_d;
   decoded_t        dec_fields;
   logic [XLEN-1:0] dec_imm;
   logic            main_valid, main_valid_d, skid_valid, skid_valid_d, in_ready_q;
   logic            accept, fire;

   mips_field_decoder #(.XLEN(XLEN), .BR_SHIFT(BR_SHIFT)) u_field_decoder (
      .insn   (in_insn),
      .fields (dec_fields),
      .imm    (dec_imm)
   );

   assign in_entry = '{pc: in_pc, imm: dec_imm, f: dec_fields};
   assign accept   = in_valid && in_ready_q;
   assign fire     = main_valid && out_ready;

   // in_ready is registered as !skid_valid, so accept and a full skid never coincide
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid;
      skid_valid_d = skid_valid;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (fire) begin
         if (skid_valid) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_d = in_entry;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!main_valid) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
         end else begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         main_q        <= '0;
         skid_q        <= '0;
         main_valid    <= 1'b0;
         skid_valid    <= 1'b0;
         in_ready_q    <= 1'b0;
         decoded_count <= '0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_valid <= main_valid_d;
         skid_valid <= skid_valid_d;
         in_ready_q <= !skid_valid_d;
         if (fire && !flush && (decoded_count != {CNT_WIDTH{1'b1}}))
            decoded_count <= decoded_count + 1'b1;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = main_valid;
   assign out_pc        = main_q.pc;
   assign out_imm       = main_q.imm;
   assign out_insn      = main_q.f.insn;
   assign out_opcode    = main_q.f.opcode;
   assign out_funct     = main_q.f.funct;
   assign out_rs        = main_q.f.rs;
   assign out_rt        = main_q.f.rt;
   assign out_rd        = main_q.f.rd;
   assign out_shamt     = main_q.f.shamt;
   assign out_jtarget   = main_q.f.jtarget;
   assign out_class     = main_q.f.cls;
   assign out_dest      = main_q.f.dest;
   assign out_reg_write = main_q.f.reg_write;
   assign out_illegal   = main_q.f.illegal;
   assign out_is_nop    = main_q.f.is_nop;

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: driver pushes model predictions on accepted inputs,
// a negedge monitor checks occupancy, count and the head entry on every presented output.
module tb_decode_pipe;

   logic        clock = 1'b0, reset = 1'b1, flush = 1'b0;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [31:0] in_pc = '0, in_insn = '0, out_pc, out_insn, out_imm;
   logic [5:0]  out_opcode, out_funct;
   logic [4:0]  out_rs, out_rt, out_rd, out_shamt, out_dest;
   logic [25:0] out_jtarget;
   logic [1:0]  out_class;
   logic        out_reg_write, out_illegal, out_is_nop;
   logic [15:0] decoded_count;

   decode_pipe #(.XLEN(32), .CNT_WIDTH(16), .BR_SHIFT(1)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_insn(in_insn),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_insn(out_insn),
      .out_opcode(out_opcode), .out_funct(out_funct), .out_rs(out_rs), .out_rt(out_rt),
      .out_rd(out_rd), .out_shamt(out_shamt), .out_imm(out_imm), .out_jtarget(out_jtarget),
      .out_class(out_class), .out_dest(out_dest), .out_reg_write(out_reg_write),
      .out_illegal(out_illegal), .out_is_nop(out_is_nop), .decoded_count(decoded_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] pc, insn, imm;
      logic [1:0]  cls;
      logic [4:0]  dest;
      logic        rw, ill, nop;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0, n_err = 0, exp_count = 0;
   logic mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode from the instruction-set rules, using 64-bit integer arithmetic
   function automatic exp_t model(input logic [31:0] pc, input logic [31:0] insn);
      exp_t   e;
      int     op, fn;
      longint simm;
      op   = int'(insn[31:26]);
      fn   = int'(insn[5:0]);
      simm = longint'($signed(insn[15:0]));
      e    = '0;
      e.pc = pc; e.insn = insn; e.nop = (insn == 0);
      if (op == 'h00 || op == 'h1C) begin
         if ((op == 'h00 && fn inside {'h00,'h02,'h03,'h04,'h06,'h07,'h08,'h09,'h10,'h12,'h18,'h19,
                                       'h1A,'h1B,'h20,'h21,'h22,'h23,'h24,'h25,'h26,'h27,'h2A,'h2B})
             || (op == 'h1C && fn == 'h02)) begin
            e.cls  = 2'b00;
            e.dest = (op == 'h00 && fn inside {'h18,'h19,'h1A,'h1B,'h08}) ? 5'd0 : insn[15:11];
         end else e.ill = 1;
      end else if (op == 'h02 || op == 'h03) begin
         e.cls = 2'b10; e.dest = (op == 'h03) ? 5'd31 : 5'd0;
      end else if (op inside {'h04,'h05,'h07}) begin
         e.cls = 2'b01; e.imm = 32'(simm * 4);
      end else if (op inside {'h08,'h09,'h0A,'h0B,'h20,'h23,'h24}) begin
         e.cls = 2'b01; e.imm = 32'(simm); e.dest = insn[20:16];
      end else if (op inside {'h0C,'h0D,'h0E}) begin
         e.cls = 2'b01; e.imm = {16'h0, insn[15:0]}; e.dest = insn[20:16];
      end else if (op == 'h0F) begin
         e.cls = 2'b01; e.imm = 32'(simm * 65536); e.dest = insn[20:16];
      end else if (op == 'h28 || op == 'h2B) begin
         e.cls = 2'b01; e.imm = 32'(simm);
      end else e.ill = 1;
      if (e.ill) e.cls = 2'b11;
      e.rw = !e.ill && (e.dest != 0);
      return e;
   endfunction

   always @(negedge clock) begin
      if (mon_en && !reset) begin
         exp_t e;
         check("in_ready_vs_occupancy", in_ready, sb.size() < 2);
         check("out_valid_vs_occupancy", out_valid, sb.size() != 0);
         check("decoded_count", decoded_count, exp_count);
         if (out_valid && sb.size() != 0) begin
            e = sb[0];
            check("pc", out_pc, e.pc);
            check("insn", out_insn, e.insn);
            check("raw_fields", {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct}, e.insn);
            check("jtarget", out_jtarget, e.insn[25:0]);
            check("imm", out_imm, e.imm);
            check("ctrl", {out_class, out_dest, out_reg_write, out_illegal, out_is_nop},
                  {e.cls, e.dest, e.rw, e.ill, e.nop});
            if (out_ready && !flush) begin
               void'(sb.pop_front());
               if (exp_count < 65535) exp_count++;
            end
         end
      end
   end

   task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                        input logic rdy, input logic fl, output logic acc);
      in_valid = v; in_pc = pc; in_insn = insn; out_ready = rdy; flush = fl;
      @(negedge clock);
      acc = v && in_ready && !fl;
      @(posedge clock);
      #1;
      if (fl) sb.delete();
      if (acc) sb.push_back(model(pc, insn));
   endtask

   task automatic send(input logic [31:0] pc, input logic [31:0] insn, input logic rdy);
      logic acc;
      int   n = 0;
      do begin
         cycle(1'b1, pc, insn, rdy, 1'b0, acc);
         n++;
      end while (!acc && n < 40);
      if (!acc) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout: insn %h not accepted after %0d cycles", insn, n);
      end
   endtask

   logic [5:0] op_tab [18] = '{6'h02,6'h03,6'h04,6'h05,6'h07,6'h08,6'h09,6'h0A,6'h0B,
                               6'h0C,6'h0D,6'h0E,6'h0F,6'h20,6'h23,6'h24,6'h28,6'h2B};
   logic [5:0] fn_tab [24] = '{6'h00,6'h02,6'h03,6'h04,6'h06,6'h07,6'h08,6'h09,6'h10,6'h12,
                               6'h18,6'h19,6'h1A,6'h1B,6'h20,6'h21,6'h22,6'h23,6'h24,6'h25,
                               6'h26,6'h27,6'h2A,6'h2B};

   function automatic logic [31:0] rand_insn();
      logic [31:0] w;
      int          r;
      w = $urandom;
      r = $urandom_range(0, 9);
      case (r)
         0:       w = 32'h0;
         1:       ;
         2, 3, 4: begin w[31:26] = 6'h00; w[5:0] = fn_tab[$urandom_range(0, 23)]; end
         5:       begin w[31:26] = 6'h1C; if ($urandom_range(0, 1) == 0) w[5:0] = 6'h02; end
         default: w[31:26] = op_tab[$urandom_range(0, 17)];
      endcase
      return w;
   endfunction

   typedef struct packed {
      logic [31:0] insn, imm;
      logic [1:0]  cls;
      logic [4:0]  dest;
      logic        rw, nop, ill;
   } dir_t;

   dir_t dir_tab [10] = '{
      '{32'h2509FFFC, 32'hFFFFFFFC, 2'b01, 5'd9,  1'b1, 1'b0, 1'b0},
      '{32'h3508FFFF, 32'h0000FFFF, 2'b01, 5'd8,  1'b1, 1'b0, 1'b0},
      '{32'h3C081234, 32'h12340000, 2'b01, 5'd8,  1'b1, 1'b0, 1'b0},
      '{32'h1000FFFF, 32'hFFFFFFFC, 2'b01, 5'd0,  1'b0, 1'b0, 1'b0},
      '{32'h0C000010, 32'h00000000, 2'b10, 5'd31, 1'b1, 1'b0, 1'b0},
      '{32'h00000000, 32'h00000000, 2'b00, 5'd0,  1'b0, 1'b1, 1'b0},
      '{32'hFC000000, 32'h00000000, 2'b11, 5'd0,  1'b0, 1'b0, 1'b1},
      '{32'h71095002, 32'h00000000, 2'b00, 5'd10, 1'b1, 1'b0, 1'b0},
      '{32'h0109001A, 32'h00000000, 2'b00, 5'd0,  1'b0, 1'b0, 1'b0},
      '{32'hAD090004, 32'h00000004, 2'b01, 5'd0,  1'b0, 1'b0, 1'b0}
   };

   initial begin
      logic        acc;
      logic [31:0] pc, insn, stream [5];
      int          idx, c0;

      // reset: everything low while asserted, in_ready rises on the first edge after release
      repeat (2) @(posedge clock);
      #2;
      check("reset_outputs", {in_ready, out_valid, out_pc, out_insn, out_imm, out_class,
                              out_dest, out_reg_write, out_illegal, out_is_nop, decoded_count}, 0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("in_ready_after_reset", in_ready, 1);
      check("count_after_reset", decoded_count, 0);
      mon_en = 1'b1;

      // directed encodings, each checked one cycle after its acceptance
      for (int i = 0; i < 10; i++) begin
         send(32'h400 + 32'(i * 4), dir_tab[i].insn, 1'b1);
         check("directed_valid", out_valid, 1);
         check("directed", {out_imm, out_class, out_dest, out_reg_write, out_is_nop, out_illegal},
               {dir_tab[i].imm, dir_tab[i].cls, dir_tab[i].dest, dir_tab[i].rw,
                dir_tab[i].nop, dir_tab[i].ill});
         if (i == 4) check("jal_jtarget", out_jtarget, 26'h10);
      end
      repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

      // 5-instruction stream with out_ready low on cycles 2-4
      c0 = int'(decoded_count);
      for (int i = 0; i < 5; i++) stream[i] = rand_insn();
      idx = 0;
      for (int k = 1; k <= 30 && !(idx == 5 && sb.size() == 0); k++) begin
         cycle(idx < 5, 32'h1000 + 32'(idx * 4), stream[idx % 5], !(k >= 2 && k <= 4), 1'b0, acc);
         if (acc) idx++;
      end
      check("stream_all_accepted", idx, 5);
      check("stream_count", decoded_count, c0 + 5);

      // flush with both entries full, alongside an input and an output handshake attempt
      cycle(1'b1, 32'h2000, 32'h2509FFFC, 1'b0, 1'b0, acc);
      cycle(1'b1, 32'h2004, 32'h3508FFFF, 1'b0, 1'b0, acc);
      check("full_in_ready", in_ready, 0);
      c0 = int'(decoded_count);
      cycle(1'b1, 32'h2008, 32'h3C081234, 1'b1, 1'b1, acc);
      check("flush_out_valid", out_valid, 0);
      check("flush_in_ready", in_ready, 1);
      check("flush_count", decoded_count, c0);

      // asynchronous reset pulse in the middle of a stall
      cycle(1'b1, 32'h3000, 32'h0C000010, 1'b0, 1'b0, acc);
      cycle(1'b1, 32'h3004, 32'h71095002, 1'b0, 1'b0, acc);
      mon_en = 1'b0;
      in_valid = 1'b0;
      #3 reset = 1'b1;
      #1;
      check("midstall_reset_outputs", {in_ready, out_valid, out_pc, out_insn, out_imm, out_class,
                                       out_dest, out_reg_write, out_illegal, out_is_nop,
                                       decoded_count}, 0);
      sb.delete();
      exp_count = 0;
      #2 reset = 1'b0;
      @(posedge clock);
      #1;
      check("in_ready_after_midstall_reset", in_ready, 1);
      check("out_valid_after_midstall_reset", out_valid, 0);
      mon_en = 1'b1;

      // randomized traffic with back-pressure and occasional flushes
      pc = 32'h8000;
      insn = rand_insn();
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 3) != 0, pc, insn, $urandom_range(0, 9) < 7,
               $urandom_range(0, 49) == 0, acc);
         if (acc) begin
            pc   = pc + 4;
            insn = rand_insn();
         end
      end
      for (int i = 0; i < 10 && sb.size() != 0; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      check("drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
